// File: rtl/conv_pkg.sv
// conv_pkg: shared defaults and the out_data lane mapping for the conv datapath.
// The conv core reuses win_lane() so producer and consumer agree on pixel order.
package conv_pkg;

  localparam int unsigned CONV_DW   = 8;
  localparam int unsigned CONV_WW   = 8;
  localparam int unsigned CONV_BW   = 16;
  localparam int unsigned CONV_KN   = 9;
  localparam int unsigned CONV_COLS = 20;

  // Window lanes are column-major: all rows of column c are adjacent.
  function automatic int unsigned win_lane(input int unsigned c,
                                           input int unsigned j,
                                           input int unsigned rows);
    return c * rows + j;
  endfunction

endpackage

// File: rtl/conv_gather_stage.sv
// conv_gather_stage: holds the non-final beats of a window until the final beat
// arrives. One slot per non-final beat, written by slot index.
module conv_gather_stage
  import conv_pkg::*;
#(
  parameter int unsigned BEAT_W = CONV_DW * 2 * CONV_COLS,
  parameter int unsigned SLOTS  = 1,
  parameter int unsigned IW     = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      wr_en_i,
  input  logic [IW-1:0]             wr_idx_i,
  input  logic [BEAT_W-1:0]         wr_data_i,
  output logic [SLOTS*BEAT_W-1:0]   slots_o
);

  logic [SLOTS-1:0][BEAT_W-1:0] slot_q;

  // Capture the incoming beat into the addressed slot; other slots hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q <= '0;
    end else if (wr_en_i) begin
      for (int unsigned s = 0; s < SLOTS; s++) begin
        if (wr_idx_i == IW'(s)) slot_q[s] <= wr_data_i;
      end
    end
  end

  assign slots_o = slot_q;

endmodule

// File: rtl/conv_row_gather.sv
// conv_row_gather: collects BEATS input beats of RPB rows each into one
// column-major window of RPB*BEATS rows and hands it to the conv engine with
// the weight/bias set captured on the final beat.
// Build option: CONV_GATHER_BIAS_EN builds the bias register; without it
// bias_o is tied to zero and the bias input is ignored.
module conv_row_gather
  import conv_pkg::*;
#(
  parameter int unsigned DW    = CONV_DW,
  parameter int unsigned COLS  = CONV_COLS,
  parameter int unsigned RPB   = 2,
  parameter int unsigned BEATS = 2,
  parameter int unsigned WW    = CONV_WW,
  parameter int unsigned KN    = CONV_KN,
  parameter int unsigned BW    = CONV_BW
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flush,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DW*RPB*COLS-1:0]        in_data,
  input  logic [WW*KN-1:0]              weight,
  input  logic [BW-1:0]                 bias,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DW*RPB*BEATS*COLS-1:0]  out_data,
  output logic [WW*KN-1:0]              weight_o,
  output logic [BW-1:0]                 bias_o
);

  localparam int unsigned ROWS   = RPB * BEATS;
  localparam int unsigned BEAT_W = DW * RPB * COLS;
  localparam int unsigned WIN_W  = DW * ROWS * COLS;
  localparam int unsigned SLOTS  = (BEATS > 1) ? BEATS - 1 : 1;
  localparam int unsigned CW     = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

  logic [CW-1:0]            beat_cnt_q, beat_cnt_d;
  logic                     out_valid_q, out_valid_d;
  logic [WIN_W-1:0]         win_q, win_d;
  logic [WW*KN-1:0]         weight_q;
  logic [BEATS*BEAT_W-1:0]  beats_all;

  logic is_final;
  logic accept;
  logic commit;
  logic stage_we;

  assign is_final = (beat_cnt_q == LAST_BEAT);
  // Only the final beat can stall, and only behind an unconsumed window.
  assign in_ready = !is_final || !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready && !flush;
  assign commit   = accept && is_final;
  assign stage_we = accept && !is_final;

  generate
    if (BEATS > 1) begin : g_stage
      logic [SLOTS*BEAT_W-1:0] stage_flat;

      conv_gather_stage #(
        .BEAT_W (BEAT_W),
        .SLOTS  (SLOTS),
        .IW     (CW)
      ) u_stage (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en_i   (stage_we),
        .wr_idx_i  (beat_cnt_q),
        .wr_data_i (in_data),
        .slots_o   (stage_flat)
      );

      assign beats_all = {in_data, stage_flat};
    end else begin : g_no_stage
      assign beats_all = in_data;
    end
  endgenerate

  // Next counter/valid state; flush wins over any beat or handshake.
  always_comb begin
    beat_cnt_d  = beat_cnt_q;
    out_valid_d = out_valid_q;
    if (flush) begin
      beat_cnt_d  = '0;
      out_valid_d = 1'b0;
    end else begin
      if (accept) beat_cnt_d = is_final ? '0 : beat_cnt_q + 1'b1;
      if (commit)         out_valid_d = 1'b1;
      else if (out_ready) out_valid_d = 1'b0;
    end
  end

  // Remap beat-major rows into the column-major window on a final beat.
  always_comb begin
    win_d = win_q;
    if (commit) begin
      for (int unsigned b = 0; b < BEATS; b++) begin
        for (int unsigned r = 0; r < RPB; r++) begin
          for (int unsigned c = 0; c < COLS; c++) begin
            win_d[DW*win_lane(c, b*RPB + r, ROWS) +: DW] =
              beats_all[b*BEAT_W + DW*(r*COLS + c) +: DW];
          end
        end
      end
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      beat_cnt_q  <= beat_cnt_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Window and weight registers, loaded together on a committed final beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_q    <= '0;
      weight_q <= '0;
    end else begin
      win_q <= win_d;
      if (commit) weight_q <= weight;
    end
  end

`ifdef CONV_GATHER_BIAS_EN
  logic [BW-1:0] bias_q;

  // Bias travels with the window it was sampled alongside.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      bias_q <= '0;
    else if (commit) bias_q <= bias;
  end

  assign bias_o = bias_q;
`else
  logic unused_bias;
  assign unused_bias = ^bias;
  assign bias_o      = '0;
`endif

  assign out_valid = out_valid_q;
  assign out_data  = win_q;
  assign weight_o  = weight_q;

endmodule

// File: tb/tb_conv_row_gather.sv
module tb_conv_row_gather;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Default instance: DW=8, COLS=20, RPB=2, BEATS=2.
  logic         flush, in_valid, in_ready, out_valid, out_ready;
  logic [319:0] in_data;
  logic [71:0]  weight, weight_o;
  logic [15:0]  bias, bias_o;
  logic [639:0] out_data;

  // Single-beat instance: DW=8, COLS=4, RPB=4, BEATS=1.
  logic         flush1, in_valid1, in_ready1, out_valid1, out_ready1;
  logic [127:0] in_data1, out_data1;
  logic [71:0]  weight1, weight_o1;
  logic [15:0]  bias1, bias_o1;

  conv_row_gather dut0 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .weight(weight), .bias(bias),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .weight_o(weight_o), .bias_o(bias_o)
  );

  conv_row_gather #(.DW(8), .COLS(4), .RPB(4), .BEATS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .flush(flush1),
    .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
    .weight(weight1), .bias(bias1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1),
    .weight_o(weight_o1), .bias_o(bias_o1)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [639:0] act, input logic [639:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [15:0] exp_bias(input logic [15:0] v);
`ifdef CONV_GATHER_BIAS_EN
    return v;
`else
    return 16'h0;
`endif
  endfunction

  // Beat pattern: pixel (r,c) = seed + 0x10*r + c.
  function automatic logic [319:0] mk_beat(input logic [7:0] seed);
    logic [319:0] v;
    v = '0;
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 20; c++)
        v[8*(r*20+c) +: 8] = seed + 8'(16*r) + 8'(c);
    return v;
  endfunction

  // Expected window: rows 0,1 from beat s0; rows 2,3 from beat s1; lane c*4+j.
  function automatic logic [639:0] mk_win(input logic [7:0] s0, input logic [7:0] s1);
    logic [639:0] v;
    logic [7:0]   base;
    v = '0;
    for (int c = 0; c < 20; c++)
      for (int j = 0; j < 4; j++) begin
        base = (j < 2) ? s0 : s1;
        v[8*(c*4+j) +: 8] = base + 8'(16*(j%2)) + 8'(c);
      end
    return v;
  endfunction

  function automatic logic [127:0] mk_beat1(input logic [7:0] seed);
    logic [127:0] v;
    v = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        v[8*(r*4+c) +: 8] = seed + 8'(16*r) + 8'(c);
    return v;
  endfunction

  function automatic logic [127:0] mk_win1(input logic [7:0] seed);
    logic [127:0] v;
    v = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        v[8*(c*4+r) +: 8] = seed + 8'(16*r) + 8'(c);
    return v;
  endfunction

  typedef struct {
    logic        fl;
    logic        iv;
    logic        ordy;
    logic [7:0]  seed;
    logic [7:0]  w;
    logic [15:0] b;
    logic        exp_ir;
    logic        exp_ov;
    logic [7:0]  es0;
    logic [7:0]  es1;
    logic [7:0]  ew;
    logic [15:0] eb;
  } vec_t;

  vec_t vt[17];

  task automatic drive1(input logic iv, input logic ordy, input logic [7:0] seed);
    in_valid1  = iv;
    out_ready1 = ordy;
    in_data1   = mk_beat1(seed);
    weight1    = {9{seed}};
    bias1      = {seed, 8'h5A};
  endtask

  initial begin
    //          fl  iv  or  seed   w      b        ir  ov  es0    es1    ew     eb
    vt[0]  = '{1'b0,1'b1,1'b1,8'h01,8'hA0,16'h1000,1'b1,1'b0,8'h00,8'h00,8'h00,16'h0000};
    vt[1]  = '{1'b0,1'b1,1'b1,8'h21,8'hA1,16'h1001,1'b1,1'b1,8'h01,8'h21,8'hA1,16'h1001};
    vt[2]  = '{1'b0,1'b1,1'b1,8'h41,8'hA2,16'h1002,1'b1,1'b0,8'h00,8'h00,8'h00,16'h0000};
    vt[3]  = '{1'b0,1'b1,1'b1,8'h61,8'hA3,16'h1003,1'b1,1'b1,8'h41,8'h61,8'hA3,16'h1003};
    vt[4]  = '{1'b0,1'b0,1'b1,8'h00,8'h00,16'h0000,1'b1,1'b0,8'h00,8'h00,8'h00,16'h0000};
    vt[5]  = '{1'b0,1'b1,1'b0,8'h03,8'hA5,16'h1005,1'b1,1'b0,8'h00,8'h00,8'h00,16'h0000};
    vt[6]  = '{1'b0,1'b1,1'b0,8'h23,8'hA6,16'h1006,1'b1,1'b1,8'h03,8'h23,8'hA6,16'h1006};
    vt[7]  = '{1'b0,1'b1,1'b0,8'h43,8'hA7,16'h1007,1'b1,1'b1,8'h03,8'h23,8'hA6,16'h1006};
    vt[8]  = '{1'b0,1'b1,1'b0,8'h63,8'hEE,16'hEEEE,1'b0,1'b1,8'h03,8'h23,8'hA6,16'h1006};
    vt[9]  = '{1'b0,1'b1,1'b0,8'h63,8'hEE,16'hEEEE,1'b0,1'b1,8'h03,8'h23,8'hA6,16'h1006};
    vt[10] = '{1'b0,1'b1,1'b1,8'h63,8'hB5,16'h1010,1'b1,1'b1,8'h43,8'h63,8'hB5,16'h1010};
    vt[11] = '{1'b0,1'b0,1'b1,8'h00,8'h00,16'h0000,1'b1,1'b0,8'h00,8'h00,8'h00,16'h0000};
    vt[12] = '{1'b0,1'b1,1'b1,8'h05,8'hAC,16'h100C,1'b1,1'b0,8'h00,8'h00,8'h00,16'h0000};
    vt[13] = '{1'b1,1'b1,1'b1,8'h25,8'hC0,16'hC0C0,1'b1,1'b0,8'h00,8'h00,8'h00,16'h0000};
    vt[14] = '{1'b0,1'b1,1'b1,8'h45,8'hAE,16'h100E,1'b1,1'b0,8'h00,8'h00,8'h00,16'h0000};
    vt[15] = '{1'b0,1'b1,1'b1,8'h65,8'hAF,16'h100F,1'b1,1'b1,8'h45,8'h65,8'hAF,16'h100F};
    vt[16] = '{1'b1,1'b0,1'b0,8'h00,8'h00,16'h0000,1'b1,1'b0,8'h00,8'h00,8'h00,16'h0000};

    rst_n = 1'b0;
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_data = '0; weight = '0; bias = '0;
    flush1 = 1'b0; in_valid1 = 1'b0; out_ready1 = 1'b0;
    in_data1 = '0; weight1 = '0; bias1 = '0;

    #12;
    chk("rst out_valid", out_valid, 1'b0);
    chk("rst out_data", out_data, '0);
    chk("rst weight_o", weight_o, '0);
    chk("rst bias_o", bias_o, '0);
    chk("rst in_ready", in_ready, 1'b1);
    chk("rst1 out_valid", out_valid1, 1'b0);
    chk("rst1 in_ready", in_ready1, 1'b1);

    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 17; i++) begin
      flush     = vt[i].fl;
      in_valid  = vt[i].iv;
      out_ready = vt[i].ordy;
      in_data   = mk_beat(vt[i].seed);
      weight    = {9{vt[i].w}};
      bias      = vt[i].b;
      #1;
      chk($sformatf("v%0d in_ready", i), in_ready, vt[i].exp_ir);
      @(posedge clk); #1;
      chk($sformatf("v%0d out_valid", i), out_valid, vt[i].exp_ov);
      if (vt[i].exp_ov) begin
        chk($sformatf("v%0d out_data", i), out_data, mk_win(vt[i].es0, vt[i].es1));
        chk($sformatf("v%0d weight_o", i), weight_o, {9{vt[i].ew}});
        chk($sformatf("v%0d bias_o", i), bias_o, exp_bias(vt[i].eb));
      end
      if (i == 1) chk("col0 literal", out_data[31:0], 32'h31211101);
    end
    flush = 1'b0; in_valid = 1'b0;

    // Single-beat build: every accepted beat commits a window.
    for (int k = 0; k < 3; k++) begin
      drive1(1'b1, 1'b1, 8'h02 + 8'(32*k));
      #1;
      chk($sformatf("b1 k%0d in_ready", k), in_ready1, 1'b1);
      @(posedge clk); #1;
      chk($sformatf("b1 k%0d out_valid", k), out_valid1, 1'b1);
      chk($sformatf("b1 k%0d out_data", k), out_data1, mk_win1(8'h02 + 8'(32*k)));
      chk($sformatf("b1 k%0d weight_o", k), weight_o1, {9{8'h02 + 8'(32*k)}});
      chk($sformatf("b1 k%0d bias_o", k), bias_o1, exp_bias({8'h02 + 8'(32*k), 8'h5A}));
    end
    drive1(1'b1, 1'b0, 8'h90);
    #1;
    chk("b1 stall in_ready", in_ready1, 1'b0);
    @(posedge clk); #1;
    chk("b1 stall out_valid", out_valid1, 1'b1);
    chk("b1 stall out_data", out_data1, mk_win1(8'h42));
    drive1(1'b1, 1'b1, 8'h90);
    #1;
    chk("b1 release in_ready", in_ready1, 1'b1);
    @(posedge clk); #1;
    chk("b1 release out_data", out_data1, mk_win1(8'h90));
    drive1(1'b0, 1'b1, 8'h00);
    @(posedge clk); #1;
    chk("b1 drain out_valid", out_valid1, 1'b0);

    // Reset while a window is held and the next one is half collected.
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = mk_beat(8'h07); weight = {9{8'hD7}}; bias = 16'hD007;
    @(posedge clk); #1;
    in_data = mk_beat(8'h27);
    @(posedge clk); #1;
    chk("pre-rst out_valid", out_valid, 1'b1);
    in_data = mk_beat(8'h47);
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid rst out_valid", out_valid, 1'b0);
    chk("mid rst out_data", out_data, '0);
    chk("mid rst weight_o", weight_o, '0);
    chk("mid rst bias_o", bias_o, '0);
    chk("mid rst in_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1; in_valid = 1'b1;
    in_data = mk_beat(8'h09); weight = {9{8'hB9}}; bias = 16'hB009;
    @(posedge clk); #1;
    chk("post rst beat0 out_valid", out_valid, 1'b0);
    in_data = mk_beat(8'h29);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("post rst out_valid", out_valid, 1'b1);
    chk("post rst out_data", out_data, mk_win(8'h09, 8'h29));
    chk("post rst weight_o", weight_o, {9{8'hB9}});
    chk("post rst bias_o", bias_o, exp_bias(16'hB009));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
